// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2 block: decodes bank-0 writes to 0x02-0x04 and
// produces the status byte {IRQ, FT1, FT2, 5'b0} plus a registered IRQ line.
module opl3_timers #(
  parameter int unsigned TIMER1_TICK_CYCLES = 1018,
  parameter int unsigned TIMER2_TICK_DIV    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] opl3_reg_wr,
  output logic [7:0]  status,
  output logic        irq
);

  localparam int unsigned PW = (TIMER1_TICK_CYCLES > 1) ? $clog2(TIMER1_TICK_CYCLES) : 1;
  localparam int unsigned QW = (TIMER2_TICK_DIV > 1) ? $clog2(TIMER2_TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TIMER1_TICK_CYCLES - 1);
  localparam logic [QW-1:0] Q_LAST = QW'(TIMER2_TICK_DIV - 1);

  logic       wr_valid, wr_bank;
  logic [7:0] wr_addr, wr_data;
  logic       wr_en, wr_t1, wr_t2, wr_ctl, wr_clr;
  logic       unused_data;

  logic [PW-1:0] p;
  logic [QW-1:0] q;
  logic          tick1, tick2;

  logic [7:0] t1_reload, t2_reload;
  logic [7:0] t1_cnt, t2_cnt;
  logic       st1, st2, mt1, mt2;
  logic       ft1, ft2, ft1_n, ft2_n;
  logic       t1_start, t2_start, t1_ovf, t2_ovf;

  assign {wr_valid, wr_bank, wr_addr, wr_data} = opl3_reg_wr;
  assign unused_data = ^wr_data[4:2];

  assign wr_en  = wr_valid && !wr_bank;
  assign wr_t1  = wr_en && (wr_addr == 8'h02);
  assign wr_t2  = wr_en && (wr_addr == 8'h03);
  assign wr_ctl = wr_en && (wr_addr == 8'h04) && !wr_data[7];
  assign wr_clr = wr_en && (wr_addr == 8'h04) &&  wr_data[7];

  assign tick1 = (p == P_LAST);
  assign tick2 = tick1 && (q == Q_LAST);

  // Start is a 0->1 edge of ST, so it never coincides with an overflow
  // (overflow requires ST already 1); the load therefore beats any tick.
  assign t1_start = wr_ctl && wr_data[0] && !st1;
  assign t2_start = wr_ctl && wr_data[1] && !st2;
  assign t1_ovf   = st1 && tick1 && (t1_cnt == 8'hFF);
  assign t2_ovf   = st2 && tick2 && (t2_cnt == 8'hFF);

  // A flag set from an overflow outranks a simultaneous IRQ-reset write.
  always_comb begin
    ft1_n = ft1;
    ft2_n = ft2;
    if (wr_clr) begin
      ft1_n = 1'b0;
      ft2_n = 1'b0;
    end
    if (t1_ovf && !mt1) ft1_n = 1'b1;
    if (t2_ovf && !mt2) ft2_n = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p <= '0;
      q <= '0;
    end else begin
      p <= tick1 ? '0 : p + 1'b1;
      if (tick1) q <= (q == Q_LAST) ? '0 : q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t1_reload <= '0;
      t2_reload <= '0;
      st1       <= 1'b0;
      st2       <= 1'b0;
      mt1       <= 1'b0;
      mt2       <= 1'b0;
    end else begin
      if (wr_t1) t1_reload <= wr_data;
      if (wr_t2) t2_reload <= wr_data;
      if (wr_ctl) begin
        mt1 <= wr_data[6];
        mt2 <= wr_data[5];
        st2 <= wr_data[1];
        st1 <= wr_data[0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t1_cnt <= '0;
      t2_cnt <= '0;
    end else begin
      if (t1_start)
        t1_cnt <= t1_reload;
      else if (st1 && tick1)
        t1_cnt <= t1_ovf ? t1_reload : t1_cnt + 8'd1;

      if (t2_start)
        t2_cnt <= t2_reload;
      else if (st2 && tick2)
        t2_cnt <= t2_ovf ? t2_reload : t2_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ft1 <= 1'b0;
      ft2 <= 1'b0;
      irq <= 1'b0;
    end else begin
      ft1 <= ft1_n;
      ft2 <= ft2_n;
      irq <= ft1_n || ft2_n;
    end
  end

  assign status = {irq, ft1, ft2, 5'b0};

endmodule

// File: tb/tb_opl3_timers.sv
// Directed bench for opl3_timers: timer windows, exact periods, masking,
// bank/valid filtering, coincident events and asynchronous reset.
module tb_opl3_timers;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [17:0] opl3_reg_wr = '0;
  logic [7:0]  status;
  logic        irq;

  int cyc    = 0;
  int passes = 0;
  int fails  = 0;
  int total  = 0;

  opl3_timers #(.TIMER1_TICK_CYCLES(1018), .TIMER2_TICK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .opl3_reg_wr(opl3_reg_wr),
    .status(status),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is captured by the following posedge.
  task automatic wr(input logic [7:0] a, input logic [7:0] d,
                    input logic bank = 1'b0, input logic v = 1'b1);
    opl3_reg_wr = {v, bank, a, d};
    @(negedge clk);
    opl3_reg_wr = '0;
  endtask

  task automatic wait_status(input logic [7:0] exp, input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (status === exp) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic wait_ovf(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (dut.t1_ovf === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic hold(input string tag, input int n, input logic [7:0] exp);
    logic [8:0] obs;
    bit bad;
    bad = 1'b0;
    obs = {irq, status};
    repeat (n) begin
      @(negedge clk);
      if (!bad) begin
        obs = {irq, status};
        if (obs !== {exp[7], exp}) bad = 1'b1;
      end
    end
    chk(tag, 32'(obs), 32'({exp[7], exp}));
  endtask

  initial begin
    int s, f, g, n, ovf_cnt;
    bit ok, bad;
    logic [7:0] first_bad;

    repeat (3) @(negedge clk);
    chk("reset status", 32'(status), 32'h00);
    chk("reset irq", 32'(irq), 32'h0);
    reset = 1'b0;
    hold("idle 10000", 10000, 8'h00);

    // Timer 1, reload 0xFE
    wr(8'h02, 8'hFE);
    wr(8'h04, 8'h01);
    s = cyc;
    wait_status(8'hC0, 2100, f);
    n = f - s;
    chk("t1 first overflow window", 32'((f >= 0) && (n >= 1019) && (n <= 2036)), 32'h1);
    chk("t1 irq", 32'(irq), 32'h1);
    wr(8'h04, 8'h80);
    chk("t1 clear", 32'(status), 32'h00);
    wait_status(8'hC0, 2100, g);
    chk("t1 period 2036", 32'(g - f), 32'd2036);
    hold("t1 sticky", 3000, 8'hC0);

    // Timer 2, reload 0xFF
    wr(8'h04, 8'h00);
    wr(8'h04, 8'h80);
    chk("stop+clear", 32'(status), 32'h00);
    wr(8'h03, 8'hFF);
    wr(8'h04, 8'h02);
    s = cyc;
    wait_status(8'hA0, 4100, f);
    n = f - s;
    chk("t2 first overflow window", 32'((f >= 0) && (n >= 1) && (n <= 4072)), 32'h1);
    wr(8'h04, 8'h80);
    chk("t2 clear", 32'(status), 32'h00);
    wait_status(8'hA0, 4100, g);
    chk("t2 period 4072", 32'(g - f), 32'd4072);

    // Masked Timer 1: no flag, counter still overflows
    wr(8'h04, 8'h00);
    wr(8'h04, 8'h80);
    wr(8'h02, 8'hFF);
    wr(8'h04, 8'h41);
    ovf_cnt = 0;
    bad = 1'b0;
    first_bad = status;
    repeat (5000) begin
      @(negedge clk);
      if (dut.t1_ovf === 1'b1) ovf_cnt++;
      if (!bad) begin
        first_bad = status;
        if (status !== 8'h00) bad = 1'b1;
      end
    end
    chk("masked status", 32'(first_bad), 32'h00);
    chk("masked overflow count", 32'((ovf_cnt >= 4) && (ovf_cnt <= 5)), 32'h1);

    // Bank 1 and invalid writes ignored
    wr(8'h04, 8'h00);
    wr(8'h04, 8'h80);
    wr(8'h02, 8'hFE, 1'b1, 1'b1);
    wr(8'h04, 8'h01, 1'b1, 1'b1);
    wr(8'h02, 8'hFE, 1'b0, 1'b0);
    wr(8'h04, 8'h01, 1'b0, 1'b0);
    hold("ignored writes", 3000, 8'h00);
    chk("ignored reload", 32'(dut.t1_reload), 32'hFF);
    chk("ignored start", 32'(dut.st1), 32'h0);

    // IRQ reset coincident with overflow: set wins
    wr(8'h04, 8'h01);
    wait_status(8'hC0, 2100, f);
    chk("t1 reload ff flag", 32'(f >= 0), 32'h1);
    wait_ovf(1100, ok);
    chk("ovf seen 1", 32'(ok), 32'h1);
    wr(8'h04, 8'h80);
    chk("clear vs overflow", 32'(status), 32'hC0);

    // Reload write coincident with overflow: old value reloads
    wait_ovf(1100, ok);
    chk("ovf seen 2", 32'(ok), 32'h1);
    wr(8'h02, 8'hF0);
    chk("reload old value", 32'(dut.t1_cnt), 32'hFF);
    chk("reload reg new", 32'(dut.t1_reload), 32'hF0);
    @(negedge clk);
    wait_ovf(1100, ok);
    chk("ovf seen 3", 32'(ok), 32'h1);
    @(negedge clk);
    chk("reload new value", 32'(dut.t1_cnt), 32'hF0);

    // Asynchronous reset mid-count
    #3 reset = 1'b1;
    #1;
    chk("async reset status", 32'(status), 32'h00);
    chk("async reset irq", 32'(irq), 32'h0);
    chk("async reset cnt", 32'(dut.t1_cnt), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    hold("post reset quiet", 3000, 8'h00);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
